// File: rtl/ula_arbitro.sv
// ---------------------------------------------------------------------------
// ula_arbitro
//
// Round-robin arbiter that shares one combinational ALU between two
// requesters. A transaction always takes three cycles: IDLE samples the
// requests and latches the winner's opcode/operands, EXEC presents them to
// the ALU, and DONE holds the captured result while the winner's ack pulses.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req0, req1     operation request from requester 0 / 1
//   s0, s1         3-bit ALU opcode of requester 0 / 1
//   a0, b0         operands of requester 0
//   a1, b1         operands of requester 1
//   ack0, ack1     one-cycle completion pulse (high in DONE for the winner)
//   result         last captured ALU result, held until the next capture
//   alu_a, alu_b   operands driven to the shared ALU
//   alu_s          opcode driven to the shared ALU
//   alu_f          combinational result returned by the shared ALU
//   busy           high whenever a transaction is in flight
//   gnt_id         requester owning the current or last transaction
//   op_cnt         number of completed transactions, wraps at 256
// ---------------------------------------------------------------------------
module ula_arbitro (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] s0,
   input  logic [2:0] s1,
   input  logic [2:0] a0,
   input  logic [2:0] b0,
   input  logic [2:0] a1,
   input  logic [2:0] b1,
   output logic       ack0,
   output logic       ack1,
   output logic [3:0] result,
   output logic [2:0] alu_a,
   output logic [2:0] alu_b,
   output logic [2:0] alu_s,
   input  logic [3:0] alu_f,
   output logic       busy,
   output logic       gnt_id,
   output logic [7:0] op_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_winner;
   logic       w_grant;

   logic       r_gnt;
   logic       r_last;
   logic [2:0] r_s;
   logic [2:0] r_a;
   logic [2:0] r_b;
   logic [3:0] r_result;
   logic [7:0] r_cnt;

   // State register; reset drops any transaction in flight straight to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Round-robin pick: a lone requester always wins, under contention the
   // requester that was not granted last time wins.
   always_comb begin
      w_winner = 1'b0;
      if (req0 && req1) begin
         w_winner = ~r_last;
      end else begin
         w_winner = req1;
      end
   end

   // Next-state logic and Moore outputs.
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      ack0    = 1'b0;
      ack1    = 1'b0;
      busy    = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (req0 || req1) begin
               w_grant = 1'b1;
               w_next  = EXEC;
            end
         end
         EXEC: begin
            w_next = DONE;
         end
         DONE: begin
            ack0   = ~r_gnt;
            ack1   = r_gnt;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: latch the winner on grant, capture the ALU at the end of
   // EXEC and count completions when DONE retires. last-grant resets to 1
   // so that requester 0 wins the very first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_s      <= 3'd0;
         r_a      <= 3'd0;
         r_b      <= 3'd0;
         r_result <= 4'd0;
         r_cnt    <= 8'd0;
      end else begin
         if (w_grant) begin
            r_gnt  <= w_winner;
            r_last <= w_winner;
            r_s    <= w_winner ? s1 : s0;
            r_a    <= w_winner ? a1 : a0;
            r_b    <= w_winner ? b1 : b0;
         end
         if (r_state == EXEC) begin
            r_result <= alu_f;
         end
         if (r_state == DONE) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // The ALU sees only latched values, so requester operand changes after
   // the grant cannot disturb the transaction in flight.
   assign alu_a  = r_a;
   assign alu_b  = r_b;
   assign alu_s  = r_s;
   assign result = r_result;
   assign gnt_id = r_gnt;
   assign op_cnt = r_cnt;

endmodule

// File: tb/tb_ula_arbitro.sv
// ---------------------------------------------------------------------------
// tb_ula_arbitro
//
// Bench for ula_arbitro. A behavioural ALU answers the DUT's alu_* port.
// A transaction-level model tracks the in-flight operation as an "age since
// grant" and predicts every output; a compare process checks the DUT against
// it on each falling edge. Directed scenarios pin the model with literal
// expectations, then randomized requesters exercise contention and resets.
// ---------------------------------------------------------------------------
module tb_ula_arbitro;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rq [2];
   logic [2:0] rs [2];
   logic [2:0] ra [2];
   logic [2:0] rb [2];
   logic       ack0, ack1, busy, gnt_id;
   logic [3:0] result, aluF;
   logic [2:0] alu_a, alu_b, alu_s;
   logic [7:0] op_cnt;

   int checks = 0;
   int failures = 0;
   bit cmpEn = 1'b0;
   bit prevAck [2];

   ula_arbitro dut (
      .clk(clk), .rst_n(rst_n),
      .req0(rq[0]), .req1(rq[1]),
      .s0(rs[0]), .s1(rs[1]),
      .a0(ra[0]), .b0(rb[0]), .a1(ra[1]), .b1(rb[1]),
      .ack0(ack0), .ack1(ack1), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(aluF),
      .busy(busy), .gnt_id(gnt_id), .op_cnt(op_cnt)
   );

   always #5 clk = ~clk;

   // Team 3-bit ALU: AND, OR, ADD, -, AND-NOT, OR-NOT, SUB, SLT.
   function automatic logic [3:0] aluModel(input logic [2:0] s, input logic [2:0] a, input logic [2:0] b);
      logic [3:0] ea, eb, nb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      nb = {1'b0, ~b};
      case (s)
         3'b000:  return ea & eb;
         3'b001:  return ea | eb;
         3'b010:  return ea + eb;
         3'b100:  return ea & nb;
         3'b101:  return ea | nb;
         3'b110:  return ea - eb;
         3'b111:  return (a < b) ? 4'd1 : 4'd0;
         default: return 4'd0;
      endcase
   endfunction

   assign aluF = aluModel(alu_s, alu_a, alu_b);

   // Reference model: age counts edges since the grant (0 = nothing in flight).
   int         mAge;
   logic       mGnt, mLast;
   logic [2:0] mS, mA, mB;
   logic [3:0] mRes;
   logic [7:0] mCnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mAge <= 0; mGnt <= 1'b0; mLast <= 1'b1;
         mS <= 3'd0; mA <= 3'd0; mB <= 3'd0;
         mRes <= 4'd0; mCnt <= 8'd0;
      end else if (mAge == 0) begin
         if (rq[0] || rq[1]) begin
            int w;
            w = (rq[0] && rq[1]) ? (mLast ? 0 : 1) : (rq[1] ? 1 : 0);
            mGnt <= 1'(w); mLast <= 1'(w);
            mS <= rs[w]; mA <= ra[w]; mB <= rb[w];
            mAge <= 1;
         end
      end else if (mAge == 1) begin
         mRes <= aluModel(mS, mA, mB);
         mAge <= 2;
      end else begin
         mCnt <= mCnt + 8'd1;
         mAge <= 0;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("m_ack0",   int'(ack0),   int'(mAge == 2 && mGnt == 1'b0));
         checkOutput("m_ack1",   int'(ack1),   int'(mAge == 2 && mGnt == 1'b1));
         checkOutput("m_busy",   int'(busy),   int'(mAge != 0));
         checkOutput("m_gnt_id", int'(gnt_id), int'(mGnt));
         checkOutput("m_result", int'(result), int'(mRes));
         checkOutput("m_alu_a",  int'(alu_a),  int'(mA));
         checkOutput("m_alu_b",  int'(alu_b),  int'(mB));
         checkOutput("m_alu_s",  int'(alu_s),  int'(mS));
         checkOutput("m_op_cnt", int'(op_cnt), int'(mCnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int id, input logic r, input logic [2:0] s, input logic [2:0] a, input logic [2:0] b);
      rq[id] = r; rs[id] = s; ra[id] = a; rb[id] = b;
   endtask

   task automatic resetDut();
      rq[0] = 1'b0; rq[1] = 1'b0;
      rst_n = 1'b0;
      cmpEn = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ack0"},   int'(ack0),   0);
      checkOutput({tag, "_ack1"},   int'(ack1),   0);
      checkOutput({tag, "_busy"},   int'(busy),   0);
      checkOutput({tag, "_result"}, int'(result), 0);
      checkOutput({tag, "_alu_a"},  int'(alu_a),  0);
      checkOutput({tag, "_alu_b"},  int'(alu_b),  0);
      checkOutput({tag, "_alu_s"},  int'(alu_s),  0);
      checkOutput({tag, "_gnt_id"}, int'(gnt_id), 0);
      checkOutput({tag, "_op_cnt"}, int'(op_cnt), 0);
   endtask

   // Random requesters: hold until ack, then either drop or reissue.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         step();
         if (rst_n == 1'b0) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (prevAck[i]) begin
               if ($urandom_range(0, 1) == 1)
                  setReq(i, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
               else
                  rq[i] = 1'b0;
            end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
               setReq(i, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
            end
            prevAck[i] = (i == 0) ? ack0 : ack1;
         end
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 2; i++) setReq(i, 1'b0, 3'd0, 3'd0, 3'd0);
      #1;
      resetDut();
      checkResetValues("reset");

      // Requester 0 alone: 5 + 3 = 8.
      setReq(0, 1'b1, 3'b010, 3'd5, 3'd3);
      step();
      checkOutput("d1_busy", int'(busy), 1);
      checkOutput("d1_gnt", int'(gnt_id), 0);
      step();
      checkOutput("d1_ack0", int'(ack0), 1);
      checkOutput("d1_ack1", int'(ack1), 0);
      checkOutput("d1_result", int'(result), 8);
      rq[0] = 1'b0;
      step();
      checkOutput("d1_opcnt", int'(op_cnt), 1);
      checkOutput("d1_ack0_off", int'(ack0), 0);

      // Requester 1 alone: 2 - 5 = -3 -> 4'b1101.
      setReq(1, 1'b1, 3'b110, 3'd2, 3'd5);
      step();
      step();
      checkOutput("d2_ack1", int'(ack1), 1);
      checkOutput("d2_result", int'(result), 13);
      checkOutput("d2_gnt", int'(gnt_id), 1);
      rq[1] = 1'b0;
      step();

      // Contention straight out of reset: 0 first, then 1, three cycles apart.
      resetDut();
      setReq(0, 1'b1, 3'b001, 3'd4, 3'd1);
      setReq(1, 1'b1, 3'b000, 3'd6, 3'd3);
      step();
      step();
      checkOutput("d3_ack0", int'(ack0), 1);
      rq[0] = 1'b0;
      step();
      step();
      checkOutput("d3_ack1_early", int'(ack1), 0);
      step();
      checkOutput("d3_ack1", int'(ack1), 1);
      checkOutput("d3_result", int'(result), 2);
      rq[1] = 1'b0;
      step();

      // Both held for four transactions: grants alternate 0,1,0,1.
      resetDut();
      setReq(0, 1'b1, 3'b010, 3'd1, 3'd1);
      setReq(1, 1'b1, 3'b010, 3'd7, 3'd7);
      for (int t = 0; t < 4; t++) begin
         step();
         checkOutput($sformatf("d4_gnt%0d", t), int'(gnt_id), t % 2);
         step();
         step();
      end
      checkOutput("d4_opcnt", int'(op_cnt), 4);
      rq[0] = 1'b0; rq[1] = 1'b0;
      step();

      // Operand change after the grant must not affect the result: 2 < 5.
      setReq(0, 1'b1, 3'b111, 3'd2, 3'd5);
      step();
      ra[0] = 3'd7;
      step();
      checkOutput("d5_result", int'(result), 1);
      checkOutput("d5_ack0", int'(ack0), 1);
      rq[0] = 1'b0;
      step();

      // Reset during EXEC aborts; a fresh req1 then completes normally.
      setReq(0, 1'b1, 3'b010, 3'd3, 3'd3);
      step();
      rst_n = 1'b0;
      rq[0] = 1'b0;
      #1;
      checkResetValues("d6_abort");
      step();
      checkResetValues("d6_held");
      rst_n = 1'b1;
      setReq(1, 1'b1, 3'b010, 3'd1, 3'd2);
      step();
      checkOutput("d6_gnt", int'(gnt_id), 1);
      step();
      checkOutput("d6_ack1", int'(ack1), 1);
      checkOutput("d6_result", int'(result), 3);
      rq[1] = 1'b0;
      step();
      checkOutput("d6_opcnt", int'(op_cnt), 1);

      // Randomized traffic against the model.
      prevAck[0] = 1'b0; prevAck[1] = 1'b0;
      applyStimulus(3000);
      rq[0] = 1'b0; rq[1] = 1'b0;
      step();
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
